// File: rtl/keypad_pkg.sv
// Shared types and helpers for the parametrised matrix-keypad scanner.
// Default timing constants assume a 50 MHz system clock.
package keypad_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DEB_P,
        SCAN,
        REPORT,
        HELD,
        DEB_R,
        WAIT_R
    } state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEF_SETTLE_CYCLES   = 2;
    localparam int DEF_REPEAT_DELAY    = 25_000_000;
    localparam int DEF_REPEAT_RATE     = 5_000_000;

    // Smallest w with 2**w >= n.
    function automatic int keypad_clog2(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    // Bits needed to hold max_val, never less than one.
    function automatic int keypad_width(input int max_val);
        int w;
        w = keypad_clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int keypad_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter; done_o flags terminal count zero.
// clear_i wins over load_i, which wins over en_i; the count never wraps below zero.
module cycle_timer
    import keypad_pkg::*;
#(
    parameter int MAX_COUNT = 1,
    parameter int W         = keypad_width(MAX_COUNT)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/keypad_scanner_param.sv
// ROWS x COLS active-low keypad scanner: debounced press/release, column sweep
// with settle delay, multi-key rejection and optional auto-repeat.
//
// state  | meaning
// IDLE   | all columns driven low, waiting for any low row
// DEB_P  | press debounce, aborts back to IDLE if rows go all-high
// SCAN   | drive one column at a time, settle, sample, accumulate hits
// REPORT | publish key_code, pulse key_valid, raise key_held
// HELD   | key down; repeat timer runs when auto-repeat is enabled
// DEB_R  | release debounce, repeat timer paused
// WAIT_R | multi-key press: wait for debounced release, no events
module keypad_scanner_param
    import keypad_pkg::*;
#(
    parameter int ROWS            = 4,
    parameter int COLS            = 4,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int SETTLE_CYCLES   = DEF_SETTLE_CYCLES,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEF_REPEAT_RATE,
    localparam int CODE_W         = keypad_clog2(ROWS * COLS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ROWS-1:0]   row_i,
    output logic [COLS-1:0]   col_o,
    output logic              key_valid,
    output logic              key_repeat,
    output logic [CODE_W-1:0] key_code,
    output logic              key_held,
    output logic              key_release,
    output logic              key_multi
);

    localparam int CIW     = keypad_width(COLS - 1);
    localparam int DEB_MAX = keypad_max(DEBOUNCE_CYCLES - 1, SETTLE_CYCLES);
    localparam int DW      = keypad_width(DEB_MAX);
    localparam int REP_MAX = keypad_max(REPEAT_DELAY - 1, REPEAT_RATE - 1);
    localparam int RW      = keypad_width(REP_MAX);

    localparam logic [DW-1:0]  DEB_LOAD    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0]  SETTLE_LOAD = DW'(SETTLE_CYCLES);
    localparam logic [RW-1:0]  RDLY_LOAD   = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0]  RRATE_LOAD  = RW'(REPEAT_RATE - 1);
    localparam logic [CIW-1:0] LAST_COL    = CIW'(COLS - 1);

    state_t            state_q, state_d;
    logic [CIW-1:0]    col_idx_q, col_idx_d;
    logic              found_q, found_d;
    logic              multi_q, multi_d;
    logic [CODE_W-1:0] hit_code_q, hit_code_d;
    logic [CODE_W-1:0] key_code_q, key_code_d;
    logic              valid_q, valid_d;
    logic              rpt_q, rpt_d;
    logic              held_q, held_d;
    logic              rel_q, rel_d;
    logic              mpulse_q, mpulse_d;

    logic              deb_clear, deb_load, deb_en, deb_done;
    logic [DW-1:0]     deb_val;
    logic              rep_clear, rep_load, rep_en, rep_done;
    logic [RW-1:0]     rep_val;

    logic              rows_idle;
    int                low_cnt;
    logic [CODE_W-1:0] samp_code;
    logic              scan_found, scan_multi;

    // One timer serves both debounce and per-column settle; they never overlap.
    cycle_timer #(
        .MAX_COUNT (DEB_MAX),
        .W         (DW)
    ) u_deb_timer (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (deb_clear),
        .load_i     (deb_load),
        .load_val_i (deb_val),
        .en_i       (deb_en),
        .done_o     (deb_done)
    );

    cycle_timer #(
        .MAX_COUNT (REP_MAX),
        .W         (RW)
    ) u_rep_timer (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (rep_clear),
        .load_i     (rep_load),
        .load_val_i (rep_val),
        .en_i       (rep_en),
        .done_o     (rep_done)
    );

    assign rows_idle = &row_i;

    always_comb begin
        low_cnt   = 0;
        samp_code = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (!row_i[r]) begin
                low_cnt   = low_cnt + 1;
                samp_code = CODE_W'(r * COLS) + CODE_W'(col_idx_q);
            end
        end
    end

    // A second hit is multi-key whether it comes from the same column or another.
    assign scan_found = found_q || (low_cnt == 1);
    assign scan_multi = multi_q || (low_cnt > 1) || ((low_cnt == 1) && found_q);

    always_comb begin
        state_d    = state_q;
        col_idx_d  = col_idx_q;
        found_d    = found_q;
        multi_d    = multi_q;
        hit_code_d = hit_code_q;
        key_code_d = key_code_q;
        held_d     = held_q;
        valid_d    = 1'b0;
        rpt_d      = 1'b0;
        rel_d      = 1'b0;
        mpulse_d   = 1'b0;
        deb_clear  = 1'b0;
        deb_load   = 1'b0;
        deb_val    = DEB_LOAD;
        deb_en     = 1'b0;
        rep_clear  = 1'b0;
        rep_load   = 1'b0;
        rep_val    = RDLY_LOAD;
        rep_en     = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rows_idle) begin
                    state_d  = DEB_P;
                    deb_load = 1'b1;
                end else begin
                    deb_clear = 1'b1;
                end
            end

            DEB_P: begin
                if (rows_idle) begin
                    state_d = IDLE;
                end else if (deb_done) begin
                    state_d   = SCAN;
                    col_idx_d = '0;
                    found_d   = 1'b0;
                    multi_d   = 1'b0;
                    deb_load  = 1'b1;
                    deb_val   = SETTLE_LOAD;
                end else begin
                    deb_en = 1'b1;
                end
            end

            SCAN: begin
                if (!deb_done) begin
                    deb_en = 1'b1;
                end else begin
                    found_d = scan_found;
                    multi_d = scan_multi;
                    if ((low_cnt == 1) && !found_q) begin
                        hit_code_d = samp_code;
                    end
                    if (col_idx_q == LAST_COL) begin
                        if (scan_multi) begin
                            mpulse_d = 1'b1;
                            state_d  = WAIT_R;
                            deb_load = 1'b1;
                        end else if (scan_found) begin
                            state_d = REPORT;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        col_idx_d = col_idx_q + CIW'(1);
                        deb_load  = 1'b1;
                        deb_val   = SETTLE_LOAD;
                    end
                end
            end

            REPORT: begin
                key_code_d = hit_code_q;
                valid_d    = 1'b1;
                held_d     = 1'b1;
                rep_load   = 1'b1;
                state_d    = HELD;
            end

            HELD: begin
                if (rows_idle) begin
                    state_d  = DEB_R;
                    deb_load = 1'b1;
                end else if (REPEAT_EN != 0) begin
                    if (rep_done) begin
                        valid_d  = 1'b1;
                        rpt_d    = 1'b1;
                        rep_load = 1'b1;
                        rep_val  = RRATE_LOAD;
                    end else begin
                        rep_en = 1'b1;
                    end
                end
            end

            DEB_R: begin
                // Repeat timer is left untouched here so HELD resumes the cadence.
                if (!rows_idle) begin
                    state_d = HELD;
                end else if (deb_done) begin
                    rel_d     = 1'b1;
                    held_d    = 1'b0;
                    rep_clear = 1'b1;
                    state_d   = IDLE;
                end else begin
                    deb_en = 1'b1;
                end
            end

            WAIT_R: begin
                if (!rows_idle) begin
                    deb_load = 1'b1;
                end else if (deb_done) begin
                    state_d = IDLE;
                end else begin
                    deb_en = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            col_idx_q  <= '0;
            found_q    <= 1'b0;
            multi_q    <= 1'b0;
            hit_code_q <= '0;
            key_code_q <= '0;
            valid_q    <= 1'b0;
            rpt_q      <= 1'b0;
            held_q     <= 1'b0;
            rel_q      <= 1'b0;
            mpulse_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_idx_q  <= col_idx_d;
            found_q    <= found_d;
            multi_q    <= multi_d;
            hit_code_q <= hit_code_d;
            key_code_q <= key_code_d;
            valid_q    <= valid_d;
            rpt_q      <= rpt_d;
            held_q     <= held_d;
            rel_q      <= rel_d;
            mpulse_q   <= mpulse_d;
        end
    end

    assign col_o       = (state_q == SCAN) ? ~(COLS'(1) << col_idx_q) : '0;
    assign key_valid   = valid_q;
    assign key_repeat  = rpt_q;
    assign key_code    = key_code_q;
    assign key_held    = held_q;
    assign key_release = rel_q;
    assign key_multi   = mpulse_q;

endmodule

// File: tb/tb_keypad_scanner_param.sv
// Directed bench for keypad_scanner_param on a 4x4 matrix with short timing;
// a second instance with auto-repeat disabled shares the same key stimulus.
module tb_keypad_scanner_param;

    localparam int TD  = 8;
    localparam int TS  = 2;
    localparam int TRD = 40;
    localparam int TRR = 10;

    logic        clk;
    logic        reset;
    logic [15:0] keys;

    logic [3:0]  row_m, col_m, row_n, col_n;
    logic [3:0]  code_m, code_n;
    logic        key_valid, key_repeat, key_held, key_release, key_multi;
    logic        nr_valid, nr_repeat, nr_held, nr_release, nr_multi;

    int checks = 0;
    int errors = 0;
    int kv_cnt = 0;
    int rel_cnt = 0;
    int mul_cnt = 0;
    int nr_kv_cnt = 0;
    int excl_err = 0;

    // Key k = r*4+c shorts row r to column c.
    function automatic logic [3:0] row_model(input logic [15:0] k, input logic [3:0] col);
        logic [3:0] r;
        r = 4'hF;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (k[i*4+j] && !col[j]) r[i] = 1'b0;
        return r;
    endfunction

    assign row_m = row_model(keys, col_m);
    assign row_n = row_model(keys, col_n);

    keypad_scanner_param #(
        .ROWS(4), .COLS(4), .DEBOUNCE_CYCLES(TD), .SETTLE_CYCLES(TS),
        .REPEAT_EN(1), .REPEAT_DELAY(TRD), .REPEAT_RATE(TRR)
    ) dut (
        .clk(clk), .reset(reset), .row_i(row_m), .col_o(col_m),
        .key_valid(key_valid), .key_repeat(key_repeat), .key_code(code_m),
        .key_held(key_held), .key_release(key_release), .key_multi(key_multi)
    );

    keypad_scanner_param #(
        .ROWS(4), .COLS(4), .DEBOUNCE_CYCLES(TD), .SETTLE_CYCLES(TS),
        .REPEAT_EN(0), .REPEAT_DELAY(TRD), .REPEAT_RATE(TRR)
    ) dut_nr (
        .clk(clk), .reset(reset), .row_i(row_n), .col_o(col_n),
        .key_valid(nr_valid), .key_repeat(nr_repeat), .key_code(code_n),
        .key_held(nr_held), .key_release(nr_release), .key_multi(nr_multi)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (key_valid) kv_cnt++;
        if (key_release) rel_cnt++;
        if (key_multi) mul_cnt++;
        if (nr_valid) nr_kv_cnt++;
        if ((int'(key_valid) + int'(key_release) + int'(key_multi)) > 1) excl_err++;
    endtask

    // which: 0 key_valid, 1 key_release, 2 key_multi; n = steps taken, -1 on timeout.
    task automatic wait_evt(input int which, input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            step();
            if ((which == 0 && key_valid) || (which == 1 && key_release) ||
                (which == 2 && key_multi)) begin
                n = i;
                break;
            end
        end
    endtask

    int n;
    int rep_offs[4];
    int rep_n, good_rep, snap_kv, snap_rel, snap_nr;

    initial begin
        reset = 1'b1;
        keys  = '0;
        repeat (3) step();

        chk("reset_col", col_m, 4'h0);
        chk("reset_valid", key_valid, 0);
        chk("reset_repeat", key_repeat, 0);
        chk("reset_code", code_m, 0);
        chk("reset_held", key_held, 0);
        chk("reset_release", key_release, 0);
        chk("reset_multi", key_multi, 0);

        reset = 1'b0;
        repeat (3) step();

        // Clean press of row 2 / col 1: first sample on step 1, valid 21 cycles later.
        keys[9] = 1'b1;
        wait_evt(0, 40, n);
        chk("press_latency", n, 22);
        chk("press_code", code_m, 9);
        chk("press_held", key_held, 1);
        chk("press_not_repeat", key_repeat, 0);
        step();
        chk("valid_one_cycle", key_valid, 0);
        keys[9] = 1'b0;
        wait_evt(1, 30, n);
        chk("release_latency", n, 9);
        chk("release_code", code_m, 9);
        chk("release_held", key_held, 0);
        repeat (4) step();

        // Bounce: 3 low, 1 high, then stable low; re-entry into DEB_P on step 5.
        keys[9] = 1'b1;
        repeat (3) step();
        keys[9] = 1'b0;
        step();
        keys[9] = 1'b1;
        wait_evt(0, 40, n);
        chk("bounce_latency", n, 22);
        chk("bounce_code", code_m, 9);
        chk("nr_held", nr_held, 1);

        // Hold 75 cycles: repeats at +40,+50,+60,+70 on the repeating instance only.
        snap_nr  = nr_kv_cnt;
        rep_n    = 0;
        good_rep = 0;
        for (int i = 0; i < 4; i++) rep_offs[i] = -1;
        for (int i = 1; i <= 75; i++) begin
            step();
            if (key_valid) begin
                if (rep_n < 4) rep_offs[rep_n] = i;
                rep_n++;
                if (key_repeat && code_m == 4'd9) good_rep++;
            end
        end
        chk("repeat_count", rep_n, 4);
        chk("repeat_off0", rep_offs[0], 40);
        chk("repeat_off1", rep_offs[1], 50);
        chk("repeat_off2", rep_offs[2], 60);
        chk("repeat_off3", rep_offs[3], 70);
        chk("repeat_flag_code", good_rep, 4);
        chk("no_repeat_when_disabled", nr_kv_cnt - snap_nr, 0);

        // Release glitch: 4 high then low; cadence resumes 5 cycles late (+85).
        snap_rel = rel_cnt;
        keys[9]  = 1'b0;
        repeat (4) step();
        keys[9] = 1'b1;
        wait_evt(0, 30, n);
        chk("glitch_resume", n, 6);
        chk("glitch_is_repeat", key_repeat, 1);
        chk("glitch_no_release", rel_cnt - snap_rel, 0);
        chk("glitch_held", key_held, 1);
        keys[9] = 1'b0;
        wait_evt(1, 30, n);
        chk("release2_latency", n, 9);
        repeat (4) step();

        // Keys (0,0) and (0,3) together: multi pulse at end of scan, code stays 9.
        snap_kv  = kv_cnt;
        snap_rel = rel_cnt;
        keys[0]  = 1'b1;
        keys[3]  = 1'b1;
        wait_evt(2, 40, n);
        chk("multi_latency", n, 21);
        chk("multi_code", code_m, 9);
        chk("multi_held", key_held, 0);
        keys = '0;
        repeat (15) step();
        chk("multi_no_valid", kv_cnt - snap_kv, 0);
        chk("multi_no_release", rel_cnt - snap_rel, 0);
        chk("multi_pulses", mul_cnt, 1);

        // Reset mid-scan, then a fresh press of row 3 / col 3.
        keys[15] = 1'b1;
        repeat (12) step();
        chk("scan_col1_driven", col_m, 4'b1101);
        reset = 1'b1;
        step();
        chk("midreset_col", col_m, 4'h0);
        chk("midreset_code", code_m, 0);
        chk("midreset_valid", key_valid, 0);
        chk("midreset_held", key_held, 0);
        chk("midreset_multi", key_multi, 0);
        keys = '0;
        step();
        reset = 1'b0;
        repeat (2) step();
        keys[15] = 1'b1;
        wait_evt(0, 40, n);
        chk("post_reset_latency", n, 22);
        chk("post_reset_code", code_m, 15);
        keys[15] = 1'b0;
        wait_evt(1, 30, n);
        chk("post_reset_release", n, 9);
        chk("post_reset_rel_code", code_m, 15);

        chk("event_exclusive", excl_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
